// File: rtl/router_pkt_framer.sv
// Source stage for the 1x3 router: buffers a whole payload, then frames it as
// header + payload + parity on din/pkt_valid, honouring busy, and reports status.
module router_pkt_framer #(
    parameter int ERR_WAIT   = 2,
    parameter bit CORRUPT_EN = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_addr,
    input  logic [5:0] req_len,
    input  logic       req_corrupt,
    output logic       req_reject,
    input  logic       pl_valid,
    input  logic [7:0] pl_data,
    output logic       pl_ready,
    output logic       pkt_valid,
    output logic [7:0] din,
    input  logic       busy,
    input  logic       error,
    output logic       done,
    output logic       done_err
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HEADER,
        PAYLOAD,
        PARITY,
        WAIT_ERR
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [7:0]  pl_mem [64];
    logic [1:0]  addr_q;
    logic [5:0]  len_q;
    logic        corrupt_q;
    logic [5:0]  wr_idx;
    logic [5:0]  rd_idx;
    logic [7:0]  parity;
    logic        err_sticky;
    logic [7:0]  wcnt;

    logic        req_bad;
    logic        last_wr;
    logic        wait_end;

    // Parity byte as driven to the router; bit0 flipped when corruption is requested.
    function automatic logic [7:0] parity_out(input logic [7:0] p, input logic c);
        return p ^ {7'b0, c & CORRUPT_EN};
    endfunction

    assign req_ready = (state == IDLE);
    assign pl_ready  = (state == LOAD);
    assign req_bad   = (req_addr == 2'd3) || (req_len == 6'd0);
    assign last_wr   = pl_valid && (wr_idx == len_q - 6'd1);
    assign wait_end  = (wcnt == 8'(ERR_WAIT - 1));

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (req_valid && !req_bad) state_nxt = LOAD;
            LOAD:     if (last_wr)               state_nxt = HEADER;
            HEADER:   if (!busy)                 state_nxt = PAYLOAD;
            PAYLOAD:  if (!busy && !(rd_idx < len_q)) state_nxt = PARITY;
            PARITY:   if (!busy)                 state_nxt = WAIT_ERR;
            WAIT_ERR: if (wait_end)              state_nxt = IDLE;
            default:                             state_nxt = IDLE;
        endcase
    end

    // Payload buffer is plain storage and carries no reset.
    always_ff @(posedge clock) begin
        if (state == LOAD && pl_valid) pl_mem[wr_idx] <= pl_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pkt_valid  <= 1'b0;
            din        <= 8'h00;
            req_reject <= 1'b0;
            done       <= 1'b0;
            done_err   <= 1'b0;
            addr_q     <= 2'd0;
            len_q      <= 6'd0;
            corrupt_q  <= 1'b0;
            wr_idx     <= 6'd0;
            rd_idx     <= 6'd0;
            parity     <= 8'h00;
            err_sticky <= 1'b0;
            wcnt       <= 8'd0;
        end else begin
            req_reject <= 1'b0;
            done       <= 1'b0;
            done_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_bad) begin
                            req_reject <= 1'b1;
                        end else begin
                            addr_q    <= req_addr;
                            len_q     <= req_len;
                            corrupt_q <= req_corrupt;
                            parity    <= {req_len, req_addr};
                            wr_idx    <= 6'd0;
                        end
                    end
                end
                LOAD: begin
                    if (pl_valid) begin
                        parity <= parity ^ pl_data;
                        wr_idx <= wr_idx + 6'd1;
                        if (last_wr) begin
                            din       <= {len_q, addr_q};
                            pkt_valid <= 1'b1;
                        end
                    end
                end
                HEADER: begin
                    if (!busy) begin
                        din    <= pl_mem[0];
                        rd_idx <= 6'd1;
                    end
                end
                PAYLOAD: begin
                    if (!busy) begin
                        if (rd_idx < len_q) begin
                            din    <= pl_mem[rd_idx];
                            rd_idx <= rd_idx + 6'd1;
                        end else begin
                            din       <= parity_out(parity, corrupt_q);
                            pkt_valid <= 1'b0;
                        end
                    end
                end
                PARITY: begin
                    if (!busy) begin
                        din        <= 8'h00;
                        err_sticky <= 1'b0;
                        wcnt       <= 8'd0;
                    end
                end
                WAIT_ERR: begin
                    err_sticky <= err_sticky | error;
                    wcnt       <= wcnt + 8'd1;
                    if (wait_end) begin
                        done     <= 1'b1;
                        done_err <= err_sticky | error;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_router_pkt_framer.sv
// Randomized bench for router_pkt_framer: a per-packet byte-list model predicts
// the din/pkt_valid stream, parity and completion status.
module tb_router_pkt_framer;

    localparam int ERR_WAIT   = 2;
    localparam bit CORRUPT_EN = 1'b1;

    logic       clock;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_addr;
    logic [5:0] req_len;
    logic       req_corrupt;
    logic       req_reject;
    logic       pl_valid;
    logic [7:0] pl_data;
    logic       pl_ready;
    logic       pkt_valid;
    logic [7:0] din;
    logic       busy;
    logic       error;
    logic       done;
    logic       done_err;

    int n_cmp;
    int n_err;
    logic [7:0] pl_q [64];

    router_pkt_framer #(.ERR_WAIT(ERR_WAIT), .CORRUPT_EN(CORRUPT_EN)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_len(req_len), .req_corrupt(req_corrupt), .req_reject(req_reject),
        .pl_valid(pl_valid), .pl_data(pl_data), .pl_ready(pl_ready),
        .pkt_valid(pkt_valid), .din(din), .busy(busy), .error(error),
        .done(done), .done_err(done_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic reject_req(input logic [1:0] a, input logic [5:0] l);
        req_valid = 1'b1; req_addr = a; req_len = l; req_corrupt = 1'b0;
        chk("rej_req_ready", req_ready, 1);
        @(negedge clock);
        req_valid = 1'b0;
        chk("rej_pulse", req_reject, 1);
        chk("rej_pl_ready", pl_ready, 0);
        chk("rej_pkt_valid", pkt_valid, 0);
        chk("rej_idle", req_ready, 1);
        @(negedge clock);
        chk("rej_pulse_end", req_reject, 0);
        chk("rej_pl_ready2", pl_ready, 0);
    endtask

    // bmode: 0 no busy, 1 header held for two busy cycles, 2 random busy.
    // emode: 0 error low, 1 error high in the wait window, 2 random error.
    task automatic send_pkt(input logic [1:0] a, input logic [5:0] l, input logic c,
                            input int bmode, input int emode, input int abort_at);
        logic [7:0] exp [$];
        logic [7:0] par;
        logic       err_seen;
        logic       e;
        logic       acc;
        int         i;
        int         k;
        int         to;
        int         hold;

        // Reference: header, payload bytes, then XOR of all of them.
        exp.delete();
        par = {l, a};
        exp.push_back(par);
        for (int j = 0; j < int'(l); j++) begin
            exp.push_back(pl_q[j]);
            par = par ^ pl_q[j];
        end
        exp.push_back(par ^ {7'b0, c & CORRUPT_EN});

        req_valid = 1'b1; req_addr = a; req_len = l; req_corrupt = c;
        chk("req_ready", req_ready, 1);
        @(negedge clock);
        req_valid = 1'b0; req_addr = 2'($urandom); req_len = 6'($urandom); req_corrupt = 1'($urandom);
        chk("req_ready_busy", req_ready, 0);
        chk("pl_ready_load", pl_ready, 1);

        i = 0; to = 0;
        while (i < int'(l) && to < 2000) begin
            pl_valid = ($urandom_range(3) != 0);
            pl_data  = pl_valid ? pl_q[i] : 8'($urandom);
            acc      = pl_valid && pl_ready;
            @(negedge clock);
            if (acc) i++;
            to++;
        end
        pl_valid = 1'b0;
        if (to >= 2000) begin
            chk("load_timeout", 0, 1);
            return;
        end
        chk("pl_ready_off", pl_ready, 0);

        k = 0; hold = 0;
        while (k < int'(l) + 2) begin
            chk("din", din, exp[k]);
            chk("pkt_valid", pkt_valid, (k <= int'(l)));
            if (abort_at == k) begin
                reset = 1'b1; busy = 1'b0;
                @(negedge clock);
                reset = 1'b0;
                chk("abort_pkt_valid", pkt_valid, 0);
                chk("abort_din", din, 0);
                chk("abort_req_ready", req_ready, 1);
                for (int w = 0; w < ERR_WAIT + 3; w++) begin
                    @(negedge clock);
                    chk("abort_no_done", done, 0);
                end
                return;
            end
            case (bmode)
                1:       busy = (k == 0 && hold < 2);
                2:       busy = 1'($urandom_range(1));
                default: busy = 1'b0;
            endcase
            @(negedge clock);
            if (!busy) begin k++; hold = 0; end
            else hold++;
        end

        chk("post_din", din, 0);
        chk("post_pkt_valid", pkt_valid, 0);
        err_seen = 1'b0;
        for (int w = 0; w < ERR_WAIT; w++) begin
            e = (emode == 1) ? 1'b1 : (emode == 2) ? 1'($urandom_range(1)) : 1'b0;
            error = e;
            err_seen = err_seen | e;
            busy = (bmode == 2) ? 1'($urandom_range(1)) : 1'b0;
            chk("done_early", done, 0);
            @(negedge clock);
        end
        error = 1'b0; busy = 1'b0;
        chk("done", done, 1);
        chk("done_err", done_err, err_seen);
        @(negedge clock);
        chk("done_pulse_end", done, 0);
        chk("idle_ready", req_ready, 1);
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        clock = 1'b0; reset = 1'b1;
        req_valid = 1'b0; req_addr = 2'd0; req_len = 6'd0; req_corrupt = 1'b0;
        pl_valid = 1'b0; pl_data = 8'h00; busy = 1'b0; error = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_pkt_valid", pkt_valid, 0);
        chk("rst_din", din, 0);
        chk("rst_pl_ready", pl_ready, 0);
        chk("rst_req_reject", req_reject, 0);
        chk("rst_done", done, 0);
        chk("rst_done_err", done_err, 0);
        reset = 1'b0;

        pl_q[0] = 8'h11; pl_q[1] = 8'h22; pl_q[2] = 8'h33; pl_q[3] = 8'h44;
        send_pkt(2'd1, 6'd4, 1'b0, 0, 0, -1);
        send_pkt(2'd1, 6'd4, 1'b0, 1, 0, -1);
        send_pkt(2'd1, 6'd4, 1'b1, 0, 1, -1);

        reject_req(2'd3, 6'd5);
        reject_req(2'd0, 6'd0);

        for (int j = 0; j < 63; j++) pl_q[j] = 8'(j);
        send_pkt(2'd2, 6'd63, 1'b0, 2, 0, -1);

        for (int j = 0; j < 64; j++) pl_q[j] = 8'($urandom);
        send_pkt(2'd0, 6'd10, 1'b0, 0, 0, 4);
        pl_q[0] = 8'h11; pl_q[1] = 8'h22; pl_q[2] = 8'h33; pl_q[3] = 8'h44;
        send_pkt(2'd1, 6'd4, 1'b0, 0, 0, -1);

        repeat (25) begin
            if ($urandom_range(4) == 0) begin
                if ($urandom_range(1) == 1) reject_req(2'd3, 6'($urandom));
                else                        reject_req(2'($urandom), 6'd0);
            end else begin
                for (int j = 0; j < 64; j++) pl_q[j] = 8'($urandom);
                send_pkt(2'($urandom_range(2)), 6'($urandom_range(63, 1)), 1'($urandom_range(1)),
                         int'($urandom_range(2)), 2, -1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
